// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] sponge definitions.
// Lane geometry, squeeze FSM encoding, lane slicing.
package keccak_pkg;

  localparam int LANE_W    = 64;
  localparam int STATE_W   = 1600;
  localparam int NUM_LANES = 25;

  typedef enum logic [1:0] {
    SQ_IDLE      = 2'd0,
    SQ_EMIT      = 2'd1,
    SQ_PERM_WAIT = 2'd2
  } sq_state_e;

  // Lane i of the state; out-of-range indices read as zero.
  function automatic logic [LANE_W-1:0] lane_slice(
    input logic [STATE_W-1:0] s,
    input int                 i
  );
    logic [LANE_W-1:0] r;
    r = '0;
    if (i >= 0 && i < NUM_LANES) begin
      r = s[LANE_W*i +: LANE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/keccak_lane_select.sv
// Lane multiplexer over the registered sponge state.
// Only lanes below RATE_WORDS are reachable.
module keccak_lane_select
  import keccak_pkg::*;
#(
  parameter int RATE_WORDS = 9,
  parameter int SEL_W      = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic [SEL_W-1:0]   sel,
  output logic [LANE_W-1:0]  lane
);

  logic [LANE_W-1:0] lanes [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lanes[g] = lane_slice(state, g);
  end

  // Pick the rate lane addressed by sel.
  always_comb begin
    lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i < RATE_WORDS && int'(sel) == i) begin
        lane = lanes[i];
      end
    end
  end

endmodule

// File: rtl/keccak_squeeze.sv
// Squeeze side of the Keccak sponge.
// Streams rate lanes, re-permuting between blocks.
module keccak_squeeze
  import keccak_pkg::*;
#(
  parameter int RATE_WORDS = 9,
  parameter int OUT_WORDS  = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANE_W-1:0]  out_data,
  output logic               out_last,
  output logic               perm_req,
  output logic [STATE_W-1:0] perm_state,
  input  logic               perm_ack,
  input  logic [STATE_W-1:0] perm_result,
  output logic               busy
);

  localparam int LW =
    (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int WW =
    (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  localparam logic [LW-1:0] LANE_MAX =
    LW'(RATE_WORDS - 1);
  localparam logic [WW-1:0] WORD_MAX =
    WW'(OUT_WORDS - 1);

  sq_state_e           fsm_q;
  sq_state_e           fsm_d;
  logic [STATE_W-1:0]  state_q;
  logic [LW-1:0]       lane_q;
  logic [LW-1:0]       lane_d;
  logic [WW-1:0]       word_q;
  logic [WW-1:0]       word_d;
  logic                alive_q;
  logic                ld_in;
  logic                ld_perm;
  logic                is_idle;
  logic                is_emit;
  logic                is_wait;
  logic                last_w;

  assign is_idle = (fsm_q == SQ_IDLE);
  assign is_emit = (fsm_q == SQ_EMIT);
  assign is_wait = (fsm_q == SQ_PERM_WAIT);
  assign last_w  = (word_q == WORD_MAX);

  keccak_lane_select #(
    .RATE_WORDS (RATE_WORDS),
    .SEL_W      (LW)
  ) u_sel (
    .state (state_q),
    .sel   (lane_q),
    .lane  (out_data)
  );

  // Outputs decoded from the registered FSM state.
  always_comb begin
    in_ready   = is_idle & alive_q;
    out_valid  = is_emit;
    out_last   = is_emit & last_w;
    perm_req   = is_wait;
    busy       = ~is_idle;
    perm_state = state_q;
  end

  // Next-state, counter and load decisions.
  always_comb begin
    fsm_d   = fsm_q;
    lane_d  = lane_q;
    word_d  = word_q;
    ld_in   = 1'b0;
    ld_perm = 1'b0;
    unique case (1'b1)
      is_idle: begin
        if (in_valid && alive_q) begin
          ld_in  = 1'b1;
          lane_d = '0;
          word_d = '0;
          fsm_d  = SQ_EMIT;
        end
      end
      is_emit: begin
        if (out_ready) begin
          if (last_w) begin
            fsm_d = SQ_IDLE;
          end else if (lane_q == LANE_MAX) begin
            word_d = word_q + 1'b1;
            lane_d = '0;
            fsm_d  = SQ_PERM_WAIT;
          end else begin
            word_d = word_q + 1'b1;
            lane_d = lane_q + 1'b1;
          end
        end
      end
      is_wait: begin
        if (perm_ack) begin
          ld_perm = 1'b1;
          fsm_d   = SQ_EMIT;
        end
      end
      default: begin
        fsm_d = SQ_IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fsm_q   <= SQ_IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      alive_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      alive_q <= 1'b1;
    end
  end

  // Sponge state: loaded from absorb side or permutation core.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= '0;
    end else if (ld_in) begin
      state_q <= in_state;
    end else if (ld_perm) begin
      state_q <= perm_result;
    end
  end

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze.
// Default instance plus a single-block instance.
module tb_keccak_squeeze;

  logic          clk;
  logic          nrst;
  logic          in_valid;
  logic [1599:0] in_state;
  logic          out_ready;
  logic          perm_ack;
  logic [1599:0] perm_result;

  logic          a_in_ready, b_in_ready;
  logic          a_valid, b_valid;
  logic [63:0]   a_data, b_data;
  logic          a_last, b_last;
  logic          a_preq, b_preq;
  logic [1599:0] a_pstate, b_pstate;
  logic          a_busy, b_busy;

  int checks;
  int failures;
  int sel;

  logic          c_in_ready;
  logic          c_valid;
  logic [63:0]   c_data;
  logic          c_last;
  logic          c_preq;
  logic          c_busy;

  keccak_squeeze dut (
    .clk         (clk),
    .nrst        (nrst),
    .in_valid    (in_valid),
    .in_ready    (a_in_ready),
    .in_state    (in_state),
    .out_valid   (a_valid),
    .out_ready   (out_ready),
    .out_data    (a_data),
    .out_last    (a_last),
    .perm_req    (a_preq),
    .perm_state  (a_pstate),
    .perm_ack    (perm_ack),
    .perm_result (perm_result),
    .busy        (a_busy)
  );

  keccak_squeeze #(
    .RATE_WORDS (9),
    .OUT_WORDS  (9)
  ) dut9 (
    .clk         (clk),
    .nrst        (nrst),
    .in_valid    (in_valid),
    .in_ready    (b_in_ready),
    .in_state    (in_state),
    .out_valid   (b_valid),
    .out_ready   (out_ready),
    .out_data    (b_data),
    .out_last    (b_last),
    .perm_req    (b_preq),
    .perm_state  (b_pstate),
    .perm_ack    (perm_ack),
    .perm_result (perm_result),
    .busy        (b_busy)
  );

  always_comb begin
    c_in_ready = sel ? b_in_ready : a_in_ready;
    c_valid    = sel ? b_valid    : a_valid;
    c_data     = sel ? b_data     : a_data;
    c_last     = sel ? b_last     : a_last;
    c_preq     = sel ? b_preq     : a_preq;
    c_busy     = sel ? b_busy     : a_busy;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(
    input int k
  );
    logic [63:0] w;
    if (k < 9) w = 64'h1111_1111_1111_1111 * (k + 1);
    else       w = 64'hA0 + 64'(k - 9);
    return w;
  endfunction

  function automatic logic [1599:0] base_state();
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) begin
      if (i < 9)
        s[64*i +: 64] =
          64'h1111_1111_1111_1111 * (i + 1);
      else
        s[64*i +: 64] = 64'hDEAD_0000 + 64'(i);
    end
    return s;
  endfunction

  function automatic logic [1599:0] perm_state_v();
    logic [1599:0] s;
    for (int i = 0; i < 25; i++)
      s[64*i +: 64] = 64'hA0 + 64'(i);
    return s;
  endfunction

  task automatic run_job(
    input int sel_i,
    input int lat,
    input bit bp,
    input bit spur,
    input int nwords
  );
    int          beats;
    int          cyc;
    int          preq_n;
    int          wcnt;
    bit          stalled;
    bit          ack_prev;
    bit          rdy;
    logic [63:0] held;
    beats    = 0;
    cyc      = 0;
    preq_n   = 0;
    wcnt     = 0;
    stalled  = 0;
    ack_prev = 0;
    held     = '0;
    sel      = sel_i;
    for (int i = 0; i < 20; i++) begin
      if (c_in_ready) break;
      @(posedge clk); #1;
    end
    chk("job_in_ready", 64'(c_in_ready), 64'd1);
    in_state  = base_state();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    perm_ack  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (beats < nwords && cyc < 200) begin
      if (ack_prev)
        chk("valid_after_ack", 64'(c_valid), 64'd1);
      if (stalled) begin
        chk("stall_valid", 64'(c_valid), 64'd1);
        chk("stall_data", c_data, held);
      end
      if (c_preq) begin
        preq_n++;
        chk("valid_in_wait", 64'(c_valid), 64'd0);
      end
      perm_ack = 1'b0;
      ack_prev = 0;
      if (c_preq) begin
        if (wcnt == lat) begin
          perm_ack = 1'b1;
          ack_prev = 1;
          wcnt     = 0;
        end else begin
          wcnt++;
        end
      end
      if (spur && cyc == 3) perm_ack = 1'b1;
      in_valid = 1'b0;
      if (spur && cyc == 5) begin
        in_valid = 1'b1;
        in_state = {25{64'h5555_5555_5555_5555}};
      end
      rdy = bp ? (cyc % 2 == 0) : 1'b1;
      out_ready = rdy;
      if (c_valid && rdy) begin
        chk($sformatf("data_w%0d", beats),
            c_data, exp_word(beats));
        chk($sformatf("last_w%0d", beats),
            64'(c_last), 64'(beats == nwords - 1));
        beats++;
      end
      stalled = c_valid && !rdy;
      held    = c_data;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    perm_ack  = 1'b0;
    out_ready = 1'b1;
    chk("beat_count", 64'(beats), 64'(nwords));
    chk("perm_req_cycles", 64'(preq_n),
        64'(nwords > 9 ? lat + 1 : 0));
    chk("valid_after_last", 64'(c_valid), 64'd0);
    chk("ready_after_last", 64'(c_in_ready), 64'd1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    sel         = 0;
    nrst        = 1'b0;
    in_valid    = 1'b0;
    in_state    = '0;
    out_ready   = 1'b0;
    perm_ack    = 1'b0;
    perm_result = perm_state_v();

    #12;
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_last", 64'(a_last), 64'd0);
    chk("rst_preq", 64'(a_preq), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_data", a_data, 64'd0);
    chk("rst_pstate_lo", a_pstate[63:0], 64'd0);
    #10 nrst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(a_in_ready), 64'd1);

    run_job(0, 3, 0, 0, 16);
    run_job(0, 3, 1, 0, 16);
    run_job(0, 0, 0, 0, 16);
    run_job(0, 3, 0, 1, 16);

    sel       = 0;
    in_state  = base_state();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (a_preq) break;
      @(posedge clk); #1;
    end
    chk("mid_preq_seen", 64'(a_preq), 64'd1);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_preq", 64'(a_preq), 64'd0);
    chk("mid_rst_valid", 64'(a_valid), 64'd0);
    chk("mid_rst_busy", 64'(a_busy), 64'd0);
    chk("mid_rst_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk); #3;
    nrst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", 64'(a_in_ready), 64'd1);
    run_job(0, 3, 0, 0, 16);

    run_job(1, 3, 0, 0, 9);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
